// File: rtl/shift_unit_pipe.sv
// Two-stage valid/ready 32-bit shift unit: S1 registers operands, S2 registers
// the opcode-selected result of three log-depth mux shifters.

module shifter_ll32 (
  input  logic [31:0] a,
  input  logic [4:0]  s,
  output logic [31:0] y
);
  logic [31:0] stg [6];
  assign stg[0] = a;
  for (genvar k = 0; k < 5; k++) begin : g_stg
    localparam int SH = 1 << k;
    assign stg[k+1] = s[k] ? {stg[k][31-SH:0], {SH{1'b0}}} : stg[k];
  end
  assign y = stg[5];
endmodule

module shifter_rl32 (
  input  logic [31:0] a,
  input  logic [4:0]  s,
  output logic [31:0] y
);
  logic [31:0] stg [6];
  assign stg[0] = a;
  for (genvar k = 0; k < 5; k++) begin : g_stg
    localparam int SH = 1 << k;
    assign stg[k+1] = s[k] ? {{SH{1'b0}}, stg[k][31:SH]} : stg[k];
  end
  assign y = stg[5];
endmodule

module shifter_ra32 (
  input  logic [31:0] a,
  input  logic [4:0]  s,
  output logic [31:0] y
);
  logic [31:0] stg [6];
  assign stg[0] = a;
  // Sign bit is invariant across stages, so any stage's MSB is the fill bit.
  for (genvar k = 0; k < 5; k++) begin : g_stg
    localparam int SH = 1 << k;
    assign stg[k+1] = s[k] ? {{SH{stg[k][31]}}, stg[k][31:SH]} : stg[k];
  end
  assign y = stg[5];
endmodule

module shift_unit_pipe #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [4:0]   in_s,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_y,
  output logic         out_zero,
  output logic         out_err
);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] s1_a_q, s1_a_d;
  logic [4:0]   s1_s_q, s1_s_d;
  logic [1:0]   s1_op_q, s1_op_d;
  logic         s2_valid_q, s2_valid_d;
  logic [N-1:0] y_q, y_d;
  logic         zero_q, zero_d;
  logic         err_q, err_d;

  logic         s2_adv, accept;
  logic [N-1:0] y_ll, y_rl, y_ra, res;
  logic         res_err;

  shifter_ll32 u_ll (.a(s1_a_q), .s(s1_s_q), .y(y_ll));
  shifter_rl32 u_rl (.a(s1_a_q), .s(s1_s_q), .y(y_rl));
  shifter_ra32 u_ra (.a(s1_a_q), .s(s1_s_q), .y(y_ra));

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (s1_op_q)
      OP_SLL:  res = y_ll;
      OP_SRL:  res = y_rl;
      OP_SRA:  res = y_ra;
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_s_d     = s1_s_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    zero_d     = zero_q;
    err_d      = err_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_s_d     = in_s;
      s1_op_d    = in_op;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
    // Result regs only reload on a real op so out_y stays quiet between ops.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d    = res;
        zero_d = (res == '0);
        err_d  = res_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_s_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_s_q     <= s1_s_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      zero_q     <= zero_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = y_q;
  assign out_zero  = zero_q;
  assign out_err   = err_q;
endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed and random checks of shift_unit_pipe against hand values and a
// behavioural shift model.

module tb_shift_unit_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, out_y;
  logic [4:0]  in_s;
  logic [1:0]  in_op;
  logic        out_zero, out_err;

  int n_chk = 0;
  int n_pass = 0;

  shift_unit_pipe #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_s(in_s), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // {err, zero, y}
  function automatic logic [33:0] model(input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
    logic [31:0] y;
    case (op)
      2'b00:   y = a << s;
      2'b01:   y = a >> s;
      2'b10:   y = $unsigned($signed(a) >>> s);
      default: y = 32'h0;
    endcase
    return {op == 2'b11, y == 32'h0, y};
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
    in_valid = v; in_a = a; in_s = s; in_op = op;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s,
                        input logic [1:0] op, input logic [31:0] ey, input logic ez, input logic ee);
    drive(1'b1, a, s, op);
    cyc();
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    cyc();
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_y"}, out_y, ey);
    chk({tag, "_zero"}, {31'b0, out_zero}, {31'b0, ez});
    chk({tag, "_err"}, {31'b0, out_err}, {31'b0, ee});
    cyc();
  endtask

  initial begin
    logic [33:0] q[$];
    logic [33:0] e;
    logic [31:0] acc_a[$];
    logic [31:0] a_inc;
    int n_acc, n_del, cycles;
    logic fin, fout;

    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_y", out_y, 32'h0);
    chk("rst_out_zero", {31'b0, out_zero}, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    cyc();

    // back-to-back stream
    drive(1'b1, 32'h0000_0001, 5'd31, 2'b00); cyc();
    drive(1'b1, 32'h8000_0000, 5'd4, 2'b01);  cyc();
    chk("stream_v0", {31'b0, out_valid}, 32'd1);
    chk("stream_sll", out_y, 32'h8000_0000);
    drive(1'b1, 32'h8000_0000, 5'd4, 2'b10);  cyc();
    chk("stream_srl", out_y, 32'h0800_0000);
    drive(1'b0, 32'h0, 5'd0, 2'b00);          cyc();
    chk("stream_sra", out_y, 32'hF800_0000);
    chk("stream_v2", {31'b0, out_valid}, 32'd1);
    cyc();
    chk("stream_empty", {31'b0, out_valid}, 32'd0);

    // boundaries
    run_op("sll0", 32'hDEAD_BEEF, 5'd0, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_op("srl_zero", 32'h0000_0001, 5'd1, 2'b01, 32'h0, 1'b1, 1'b0);
    run_op("illegal", 32'hFFFF_FFFF, 5'd7, 2'b11, 32'h0, 1'b1, 1'b1);
    run_op("sra_pos", 32'h7000_0000, 5'd31, 2'b10, 32'h0, 1'b1, 1'b0);

    // back-pressure: 5 cycles with out_ready low
    out_ready = 1'b0;
    a_inc = 32'd100;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, a_inc, 5'd0, 2'b00);
      #1;
      if (in_ready) n_acc++;
      cyc();
      a_inc++;
      if (i >= 2) chk("bp_hold_y", out_y, 32'd100);
    end
    chk("bp_accepted", n_acc, 32'd2);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    out_ready = 1'b1;
    #1;
    chk("drain0", out_y, 32'd100);
    cyc();
    chk("drain1_v", {31'b0, out_valid}, 32'd1);
    chk("drain1", out_y, 32'd101);
    cyc();
    chk("drain_done", {31'b0, out_valid}, 32'd0);

    // reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 32'h1234_5678, 5'd0, 2'b00); cyc();
    drive(1'b1, 32'h0000_00FF, 5'd0, 2'b00); cyc();
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    chk("prerst_in_ready", {31'b0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_y", out_y, 32'h0);
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("postrst_in_ready", {31'b0, in_ready}, 32'd1);
    cyc();
    chk("postrst_no_pulse", {31'b0, out_valid}, 32'd0);

    // random stress against model queue
    n_acc = 0; n_del = 0; cycles = 0;
    while (n_acc < 10000 && cycles < 60000) begin
      drive($urandom_range(3) != 0, $urandom, 5'($urandom), 2'($urandom));
      out_ready = $urandom_range(3) != 0;
      #1;
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      if (fout) begin
        if (q.size() == 0) chk("rnd_spurious", {31'b0, out_valid}, 32'd0);
        else begin
          e = q.pop_front();
          chk("rnd_out", {out_err, out_zero, out_y[29:0]}, {e[33:32], e[29:0]});
          chk("rnd_y", out_y, e[31:0]);
          n_del++;
        end
      end
      if (fin) begin
        q.push_back(model(in_a, in_s, in_op));
        n_acc++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    drive(1'b0, 32'h0, 5'd0, 2'b00);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        chk("rnd_drain_y", out_y, e[31:0]);
        chk("rnd_drain_flags", {30'b0, out_err, out_zero}, {30'b0, e[33:32]});
        n_del++;
      end
      @(posedge clk); #1;
    end
    chk("rnd_accepted", n_acc, 32'd10000);
    chk("rnd_delivered", n_del, n_acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
